// File: rtl/output_drain_pkg.sv
// output_drain_pkg: shared defaults, FSM state type and drop counter width for vector_output_drain
package output_drain_pkg;
  localparam int DEFAULT_DATA_WIDTH = 19;
  localparam int DEFAULT_VECTOR_SIZE = 6;
  localparam int DROP_COUNT_WIDTH = 16;
  typedef enum logic {IDLE, SEND} drain_state_t;
endpackage

// File: rtl/output_vector_fifo.sv
// output_vector_fifo: synchronous FIFO of whole vectors with registered count driving full/empty
module output_vector_fifo #(
  parameter int WIDTH = 114,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end
  end
  assign o_data = r_mem[r_rd];
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
endmodule

// File: rtl/vector_output_drain.sv
// vector_output_drain: buffers CPU out vectors and streams them element-wise; OUTPUT_DRAIN_DROP_COUNT_EN adds dropCount
module vector_output_drain
  import output_drain_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int VECTOR_SIZE = DEFAULT_VECTOR_SIZE,
  parameter int DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]   out,
  input  logic                                outFlag,
  output logic [DATA_WIDTH-1:0]               elementData,
  output logic                                elementValid,
  input  logic                                elementReady,
  output logic [$clog2(VECTOR_SIZE)-1:0]      elementIndex,
  output logic                                elementLast,
  output logic [$clog2(DEPTH):0]              fifoCount,
  output logic                                overflow
`ifdef OUTPUT_DRAIN_DROP_COUNT_EN
  ,
  output logic [DROP_COUNT_WIDTH-1:0]         dropCount
`endif
);
  localparam int IW = $clog2(VECTOR_SIZE);
  localparam int VW = VECTOR_SIZE*DATA_WIDTH;
  drain_state_t r_state;
  logic [VW-1:0] r_sh;
  logic [IW-1:0] r_idx;
  logic r_ovf;
  logic [VW-1:0] w_head;
  logic w_full, w_empty, w_xfer, w_end, w_pop, w_push, w_drop;
  assign w_xfer = r_state == SEND && elementReady;
  assign w_end = w_xfer && r_idx == IW'(VECTOR_SIZE-1);
  assign w_pop = !w_empty && (r_state == IDLE || w_end);
  // a pop frees a slot in the same edge, so a push on full is still accepted
  assign w_push = outFlag && (!w_full || w_pop);
  assign w_drop = outFlag && !w_push;
  output_vector_fifo #(.WIDTH(VW), .DEPTH(DEPTH)) u_fifo (
    .clk(clock),
    .rst(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(out),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(fifoCount)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_sh <= '0;
      r_idx <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (w_pop) begin
        r_sh <= w_head;
        r_idx <= '0;
        r_state <= SEND;
      end else if (w_end) begin
        r_sh <= '0;
        r_idx <= '0;
        r_state <= IDLE;
      end else if (w_xfer) begin
        r_sh <= r_sh >> DATA_WIDTH;
        r_idx <= r_idx + 1'b1;
      end
    end
  end
`ifdef OUTPUT_DRAIN_DROP_COUNT_EN
  logic [DROP_COUNT_WIDTH-1:0] r_drop;
  always_ff @(posedge clock) begin
    if (reset) r_drop <= '0;
    else if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
  end
  assign dropCount = r_drop;
`endif
  assign elementValid = r_state == SEND;
  assign elementData = r_sh[DATA_WIDTH-1:0];
  assign elementIndex = r_idx;
  assign elementLast = elementValid && r_idx == IW'(VECTOR_SIZE-1);
  assign overflow = r_ovf;
endmodule

// File: tb/tb_vector_output_drain.sv
// tb_vector_output_drain: table-driven and directed checks of capture, drain, backpressure, overflow and reset
module tb_vector_output_drain;
  localparam int DW = 19;
  localparam int VS = 6;
  localparam int DEPTH = 4;
  logic clock = 1'b0;
  logic reset, outFlag, elementReady, elementValid, elementLast, overflow;
  logic [VS*DW-1:0] out;
  logic [DW-1:0] elementData;
  logic [2:0] elementIndex;
  logic [2:0] fifoCount;
`ifdef OUTPUT_DRAIN_DROP_COUNT_EN
  logic [15:0] dropCount;
`endif
  int n_pass = 0;
  int n_tot = 0;
  always #5 clock = ~clock;
  vector_output_drain #(.DATA_WIDTH(DW), .VECTOR_SIZE(VS), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .out(out),
    .outFlag(outFlag),
    .elementData(elementData),
    .elementValid(elementValid),
    .elementReady(elementReady),
    .elementIndex(elementIndex),
    .elementLast(elementLast),
    .fifoCount(fifoCount),
    .overflow(overflow)
`ifdef OUTPUT_DRAIN_DROP_COUNT_EN
    ,
    .dropCount(dropCount)
`endif
  );
  typedef struct {
    logic fl;
    logic rdy;
    logic [DW-1:0] base;
    logic ev;
    logic [DW-1:0] ed;
    logic [2:0] ei;
    logic el;
    logic [2:0] ec;
    logic eo;
  } vec_t;
  vec_t tbl[$];
  function automatic logic [VS*DW-1:0] mkvec(input logic [DW-1:0] b);
    logic [VS*DW-1:0] v;
    for (int j = 0; j < VS; j++) v[j*DW +: DW] = b + DW'(j);
    return v;
  endfunction
  task automatic add(input logic fl, rdy, input logic [DW-1:0] base, input logic ev,
                     input logic [DW-1:0] ed, input logic [2:0] ei, input logic el,
                     input logic [2:0] ec, input logic eo);
    vec_t v;
    v.fl = fl; v.rdy = rdy; v.base = base; v.ev = ev; v.ed = ed;
    v.ei = ei; v.el = el; v.ec = ec; v.eo = eo;
    tbl.push_back(v);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step(input logic fl, input logic [DW-1:0] b, input logic rdy);
    outFlag = fl;
    out = mkvec(b);
    elementReady = rdy;
    @(posedge clock);
    #1;
    outFlag = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic ev, input logic [DW-1:0] ed,
                            input logic [2:0] ei, input logic el, input logic [2:0] ec,
                            input logic eo);
    chk({tag, ".valid"}, 32'(elementValid), 32'(ev));
    if (ev) begin
      chk({tag, ".data"}, 32'(elementData), 32'(ed));
      chk({tag, ".index"}, 32'(elementIndex), 32'(ei));
    end
    chk({tag, ".last"}, 32'(elementLast), 32'(el));
    chk({tag, ".count"}, 32'(fifoCount), 32'(ec));
    chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, '0, 1'b0);
    reset = 1'b0;
  endtask
  initial begin
    int bs[5];
    bs = '{'h20, 'h30, 'h40, 'h50, 'h60};
    reset = 1'b1;
    outFlag = 1'b0;
    elementReady = 1'b0;
    out = '0;
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_out("reset", 1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("reset.data", 32'(elementData), 0);
    chk("reset.index", 32'(elementIndex), 0);
`ifdef OUTPUT_DRAIN_DROP_COUNT_EN
    chk("reset.drop_count", 32'(dropCount), 0);
`endif
    reset = 1'b0;
    add(1, 1, 'h1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 'h1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 'h2, 1, 0, 0, 0);
    add(0, 1, 0, 1, 'h3, 2, 0, 0, 0);
    add(0, 1, 0, 1, 'h4, 3, 0, 0, 0);
    add(0, 1, 0, 1, 'h5, 4, 0, 0, 0);
    add(0, 1, 0, 1, 'h6, 5, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 'h10, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 'h10, 0, 0, 0, 0);
    add(0, 1, 0, 1, 'h11, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h11, 1, 0, 0, 0);
    add(0, 0, 0, 1, 'h11, 1, 0, 0, 0);
    add(0, 1, 0, 1, 'h12, 2, 0, 0, 0);
    add(0, 1, 0, 1, 'h13, 3, 0, 0, 0);
    add(0, 0, 0, 1, 'h13, 3, 0, 0, 0);
    add(0, 0, 0, 1, 'h13, 3, 0, 0, 0);
    add(0, 1, 0, 1, 'h14, 4, 0, 0, 0);
    add(0, 1, 0, 1, 'h15, 5, 1, 0, 0);
    add(0, 0, 0, 1, 'h15, 5, 1, 0, 0);
    add(0, 0, 0, 1, 'h15, 5, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 'h20, 0, 0, 0, 0, 1, 0);
    add(1, 0, 'h30, 1, 'h20, 0, 0, 1, 0);
    add(1, 0, 'h40, 1, 'h20, 0, 0, 2, 0);
    add(1, 0, 'h50, 1, 'h20, 0, 0, 3, 0);
    add(1, 0, 'h60, 1, 'h20, 0, 0, 4, 0);
    add(1, 0, 'h70, 1, 'h20, 0, 0, 4, 1);
    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].base, tbl[i].rdy);
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ei, tbl[i].el, tbl[i].ec, tbl[i].eo);
    end
`ifdef OUTPUT_DRAIN_DROP_COUNT_EN
    chk("ovf.drop_count", 32'(dropCount), 1);
`endif
    for (int v = 0; v < 5; v++)
      for (int j = 0; j < VS; j++) begin
        chk($sformatf("drain%0d_%0d.valid", v, j), 32'(elementValid), 1);
        chk($sformatf("drain%0d_%0d.data", v, j), 32'(elementData), 32'(bs[v] + j));
        chk($sformatf("drain%0d_%0d.index", v, j), 32'(elementIndex), 32'(j));
        step(1'b0, '0, 1'b1);
      end
    expect_out("drain_end", 1'b0, '0, '0, 1'b0, '0, 1'b1);
    do_reset();
    chk("pushpop.rst_overflow", 32'(overflow), 0);
    step(1'b1, 'h80, 1'b0);
    step(1'b1, 'h90, 1'b0);
    step(1'b1, 'hA0, 1'b0);
    step(1'b1, 'hB0, 1'b0);
    step(1'b1, 'hC0, 1'b0);
    expect_out("pushpop.full", 1'b1, 'h80, 0, 1'b0, 3'd4, 1'b0);
    for (int j = 0; j < VS-1; j++) step(1'b0, '0, 1'b1);
    expect_out("pushpop.last", 1'b1, 'h85, 5, 1'b1, 3'd4, 1'b0);
    step(1'b1, 'hD0, 1'b1);
    expect_out("pushpop.after", 1'b1, 'h90, 0, 1'b0, 3'd4, 1'b0);
    do_reset();
    step(1'b1, 'hE0, 1'b1);
    step(1'b1, 'hF0, 1'b1);
    chk("b2b.count", 32'(fifoCount), 1);
    for (int c = 0; c < 2*VS; c++) begin
      chk($sformatf("b2b%0d.valid", c), 32'(elementValid), 1);
      chk($sformatf("b2b%0d.index", c), 32'(elementIndex), 32'(c % VS));
      chk($sformatf("b2b%0d.data", c), 32'(elementData), 32'(c < VS ? 'hE0 + c : 'hF0 + c - VS));
      step(1'b0, '0, 1'b1);
    end
    chk("b2b.idle", 32'(elementValid), 0);
    do_reset();
    step(1'b1, 'h100, 1'b0);
    step(1'b1, 'h110, 1'b0);
    step(1'b1, 'h120, 1'b0);
    for (int j = 0; j < 3; j++) step(1'b0, '0, 1'b1);
    expect_out("mid.before", 1'b1, 'h103, 3, 1'b0, 3'd2, 1'b0);
    reset = 1'b1;
    step(1'b0, '0, 1'b1);
    reset = 1'b0;
    expect_out("mid.reset", 1'b0, '0, '0, 1'b0, '0, 1'b0);
    chk("mid.reset.data", 32'(elementData), 0);
    chk("mid.reset.index", 32'(elementIndex), 0);
    step(1'b0, '0, 1'b1);
    chk("mid.no_resume", 32'(elementValid), 0);
    step(1'b1, 'h130, 1'b0);
    step(1'b0, '0, 1'b0);
    expect_out("mid.new", 1'b1, 'h130, 0, 1'b0, '0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
